// File: rtl/conv_win_pkg.sv
// Shared types and sizing constants for the conv sliding-window generator.
package conv_win_pkg;
  localparam int DATA_W       = 64;
  localparam int LANES        = 8;
  localparam int KMAX         = 3;
  localparam int MAX_ROW_VECS = 8192;
  // A 3x3 frame needs width >= 3, so one pixel never exceeds MAX_ROW_VECS/3 vectors.
  localparam int COL_VECS_MAX = 4096;
  localparam int DEPTH_W      = $clog2(MAX_ROW_VECS + 1);

  typedef logic [DATA_W-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/conv_win_line_buffer.sv
// Enable-gated delay line of runtime depth with a registered output.
// After the enable that presents sample n, dout_o holds sample n-depth_i.
// depth_i == 0 degenerates to a plain enable register (dout_o = sample n).
module conv_win_line_buffer
  import conv_win_pkg::*;
#(
  parameter int DEPTH_MAX = MAX_ROW_VECS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [DEPTH_W-1:0] depth_i,
  input  vec_t               din_i,
  output vec_t               dout_o
);
  localparam int AW = $clog2(DEPTH_MAX);

  vec_t          mem_q [DEPTH_MAX];
  logic [AW-1:0] wp_q, wp_d;
  vec_t          dout_q, dout_d;
  logic          bypass;

  assign bypass = (depth_i == '0);
  assign dout_o = dout_q;

  // Read-before-write at the write pointer; pointer wraps after depth_i entries.
  always_comb begin
    wp_d   = wp_q;
    dout_d = dout_q;
    if (clr_i) begin
      wp_d = '0;
    end else if (en_i) begin
      if (bypass) begin
        dout_d = din_i;
      end else begin
        dout_d = mem_q[wp_q];
        if (DEPTH_W'(wp_q) == depth_i - DEPTH_W'(1)) wp_d = '0;
        else                                          wp_d = wp_q + AW'(1);
      end
    end
  end

  // RAM write port; contents are never cleared, stale data is masked upstream.
  always_ff @(posedge clk) begin
    if (en_i && !bypass && !clr_i) mem_q[wp_q] <= din_i;
  end

  // Pointer and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q   <= '0;
      dout_q <= '0;
    end else begin
      wp_q   <= wp_d;
      dout_q <= dout_d;
    end
  end
endmodule

// File: rtl/conv_window_gen.sv
// Sliding KxK window generator (K = 1 or 3, stride 1 or 2) over a pre-padded
// raster stream of channel-group vectors. Stride 2 is built only when
// CONV_WIN_STRIDE2_EN is defined; otherwise cfg_stride2 is ignored.
//
//  state | meaning
//  IDLE  | waiting for cfg_start, config checked here
//  RUN   | accepting beats, emitting windows
//  DONE  | last beat taken, frame_done pulse
module conv_window_gen
  import conv_win_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_start,
  input  logic [15:0]                 cfg_in_channels,
  input  logic [15:0]                 cfg_img_width,
  input  logic [15:0]                 cfg_img_height,
  input  logic                        cfg_k3,
  input  logic                        cfg_stride2,
  output logic                        cfg_err,
  output logic                        busy,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  vec_t                        s_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [KMAX*KMAX*DATA_W-1:0] m_window,
  output logic                        m_last,
  output logic                        frame_done
);
  state_t             state_q, state_d;
  logic               cfg_err_q, cfg_err_d;
  logic [DEPTH_W-1:0] depth_q, depth_d, rv_q, rv_d, vec_q, vec_d;
  logic [15:0]        width_q, width_d, height_q, height_d;
  logic [15:0]        col_q, col_d, row_q, row_d;
  logic               k3_q, k3_d;
  logic               m_valid_q, m_valid_d, m_last_q, m_last_d;
  vec_t               cur_q, cur_d;

  logic [15:0] cfg_depth, cfg_k;
  logic [31:0] cfg_row_vecs;
  logic        cfg_bad, accept, last_vec, last_col, last_row, last_beat;
  logic        pos_ok, phase_ok, win_ok;

  assign cfg_depth    = cfg_in_channels / 16'(LANES);
  assign cfg_row_vecs = 32'(cfg_img_width) * 32'(cfg_depth);
  assign cfg_k        = cfg_k3 ? 16'd3 : 16'd1;
  assign cfg_bad      = (cfg_in_channels == '0) ||
                        ((cfg_in_channels % 16'(LANES)) != '0) ||
                        (cfg_row_vecs > 32'(MAX_ROW_VECS)) ||
                        (cfg_img_width < cfg_k) || (cfg_img_height < cfg_k);

  assign s_ready    = (state_q == RUN) && (!m_valid_q || m_ready);
  assign accept     = s_valid && s_ready;
  assign last_vec   = (vec_q == depth_q - DEPTH_W'(1));
  assign last_col   = (col_q == width_q - 16'd1);
  assign last_row   = (row_q == height_q - 16'd1);
  assign last_beat  = last_vec && last_col && last_row;
  assign pos_ok     = !k3_q || ((row_q >= 16'd2) && (col_q >= 16'd2));

`ifdef CONV_WIN_STRIDE2_EN
  logic s2_q, s2_d;
  // K-1 is even for both kernels, so the stride phase is just the LSB of row/col.
  assign phase_ok = !s2_q || (!row_q[0] && !col_q[0]);
`else
  logic unused_stride2;
  assign unused_stride2 = cfg_stride2;
  assign phase_ok       = 1'b1;
`endif

  assign win_ok = pos_ok && phase_ok;

  assign cfg_err    = cfg_err_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;

  // Next state, config latch, raster counters and output-stage handshake.
  always_comb begin
    state_d   = state_q;
    cfg_err_d = cfg_err_q;
    depth_d   = depth_q;
    rv_d      = rv_q;
    width_d   = width_q;
    height_d  = height_q;
    k3_d      = k3_q;
    vec_d     = vec_q;
    col_d     = col_q;
    row_d     = row_q;
    cur_d     = cur_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
`ifdef CONV_WIN_STRIDE2_EN
    s2_d      = s2_q;
`endif
    if (m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            cfg_err_d = 1'b0;
            state_d   = RUN;
            depth_d   = DEPTH_W'(cfg_depth);
            rv_d      = DEPTH_W'(cfg_row_vecs);
            width_d   = cfg_img_width;
            height_d  = cfg_img_height;
            k3_d      = cfg_k3;
            vec_d     = '0;
            col_d     = '0;
            row_d     = '0;
`ifdef CONV_WIN_STRIDE2_EN
            s2_d      = cfg_stride2;
`endif
          end
        end
      end
      RUN: begin
        if (accept) begin
          m_valid_d = win_ok;
          m_last_d  = win_ok && last_beat;
          cur_d     = s_data;
          vec_d     = last_vec ? '0 : vec_q + DEPTH_W'(1);
          if (last_vec) begin
            col_d = last_col ? '0 : col_q + 16'd1;
            if (last_col) row_d = last_row ? '0 : row_q + 16'd1;
          end
          if (last_beat) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cfg_err_q <= 1'b0;
      depth_q   <= '0;
      rv_q      <= '0;
      width_q   <= '0;
      height_q  <= '0;
      k3_q      <= 1'b0;
      vec_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      cur_q     <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
`ifdef CONV_WIN_STRIDE2_EN
      s2_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cfg_err_q <= cfg_err_d;
      depth_q   <= depth_d;
      rv_q      <= rv_d;
      width_q   <= width_d;
      height_q  <= height_d;
      k3_q      <= k3_d;
      vec_q     <= vec_d;
      col_q     <= col_d;
      row_q     <= row_d;
      cur_q     <= cur_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
`ifdef CONV_WIN_STRIDE2_EN
      s2_q      <= s2_d;
`endif
    end
  end

  // Row taps: newest row is the registered beat, older rows come from the
  // cascaded line buffers (second one is one short to absorb the first's
  // output register). Column taps hang off each row tap the same way.
  vec_t               row_tap [KMAX];
  vec_t               col_src [KMAX];
  vec_t               col1 [KMAX];
  vec_t               col2 [KMAX];
  logic [DEPTH_W-1:0] rb2_depth, cd_full, cd_short;

  assign rb2_depth  = k3_q ? rv_q - DEPTH_W'(1) : DEPTH_W'(1);
  assign cd_full    = k3_q ? depth_q : DEPTH_W'(1);
  assign cd_short   = k3_q ? depth_q - DEPTH_W'(1) : DEPTH_W'(1);
  assign row_tap[0] = cur_q;
  assign col_src[0] = s_data;
  assign col_src[1] = row_tap[1];
  assign col_src[2] = row_tap[2];

  conv_win_line_buffer #(.DEPTH_MAX(MAX_ROW_VECS)) u_row1 (
    .clk(clk), .rst(rst), .clr_i(cfg_start && !cfg_bad && state_q == IDLE), .en_i(accept),
    .depth_i(rv_q), .din_i(s_data), .dout_o(row_tap[1])
  );

  conv_win_line_buffer #(.DEPTH_MAX(MAX_ROW_VECS)) u_row2 (
    .clk(clk), .rst(rst), .clr_i(cfg_start && !cfg_bad && state_q == IDLE), .en_i(accept),
    .depth_i(rb2_depth), .din_i(row_tap[1]), .dout_o(row_tap[2])
  );

  for (genvar g = 0; g < KMAX; g++) begin : g_col
    conv_win_line_buffer #(.DEPTH_MAX(COL_VECS_MAX)) u_col_a (
      .clk(clk), .rst(rst), .clr_i(cfg_start && !cfg_bad && state_q == IDLE), .en_i(accept),
      .depth_i((g == 0) ? cd_full : cd_short), .din_i(col_src[g]), .dout_o(col1[g])
    );
    conv_win_line_buffer #(.DEPTH_MAX(COL_VECS_MAX)) u_col_b (
      .clk(clk), .rst(rst), .clr_i(cfg_start && !cfg_bad && state_q == IDLE), .en_i(accept),
      .depth_i(cd_short), .din_i(col1[g]), .dout_o(col2[g])
    );
  end

  // Window assembly: slot [r][c], r0 oldest row, c0 leftmost column.
  always_comb begin
    m_window = '0;
    if (k3_q) begin
      for (int r = 0; r < KMAX; r++) begin
        m_window[(r*KMAX+0)*DATA_W +: DATA_W] = col2[KMAX-1-r];
        m_window[(r*KMAX+1)*DATA_W +: DATA_W] = col1[KMAX-1-r];
        m_window[(r*KMAX+2)*DATA_W +: DATA_W] = row_tap[KMAX-1-r];
      end
    end else begin
      m_window[DATA_W-1:0] = cur_q;
    end
  end
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: expected windows come from a pixel-
// coordinate model of the sliding window over a beat-index-valued stream.
module tb_conv_window_gen;
  import conv_win_pkg::*;

  localparam int WW    = KMAX*KMAX*DATA_W;
  localparam int LIMIT = 5000;
`ifdef CONV_WIN_STRIDE2_EN
  localparam bit STRIDE_EN = 1'b1;
`else
  localparam bit STRIDE_EN = 1'b0;
`endif

  logic          clk, rst, cfg_start, cfg_k3, cfg_stride2;
  logic [15:0]   cfg_in_channels, cfg_img_width, cfg_img_height;
  logic          cfg_err, busy, s_valid, s_ready, m_valid, m_ready, m_last, frame_done;
  vec_t          s_data;
  logic [WW-1:0] m_window;

  conv_window_gen dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_in_channels(cfg_in_channels),
    .cfg_img_width(cfg_img_width), .cfg_img_height(cfg_img_height), .cfg_k3(cfg_k3),
    .cfg_stride2(cfg_stride2), .cfg_err(cfg_err), .busy(busy), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_window(m_window), .m_last(m_last), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] w;
    logic          last;
  } win_t;

  win_t          exp_q[$];
  bit            wb_q[$];
  logic [WW-1:0] got_q[$];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start(input int ch, input int w, input int h, input bit k3, input bit s2);
    @(negedge clk);
    cfg_in_channels = 16'(ch);
    cfg_img_width   = 16'(w);
    cfg_img_height  = 16'(h);
    cfg_k3          = k3;
    cfg_stride2     = s2;
    cfg_start       = 1'b1;
    @(negedge clk);
    cfg_start       = 1'b0;
    #1;
  endtask

  function automatic void build(input int D, input int W, input int H, input bit k3,
                                input bit s2, input logic [63:0] base);
    int K = k3 ? 3 : 1;
    int S = (s2 && STRIDE_EN) ? 2 : 1;
    exp_q.delete();
    wb_q.delete();
    got_q.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int v = 0; v < D; v++) begin
          win_t e;
          bit   ok = (r >= K-1) && (c >= K-1) && ((r-(K-1)) % S == 0) && ((c-(K-1)) % S == 0);
          wb_q.push_back(ok);
          if (ok) begin
            e.w = '0;
            if (K == 3) begin
              for (int wr = 0; wr < 3; wr++)
                for (int wc = 0; wc < 3; wc++)
                  e.w[(wr*KMAX+wc)*DATA_W +: DATA_W] = base + 64'(((r-2+wr)*W + (c-2+wc))*D + v);
            end else begin
              e.w[DATA_W-1:0] = base + 64'((r*W + c)*D + v);
            end
            e.last = (r == H-1) && (c == W-1) && (v == D-1);
            exp_q.push_back(e);
          end
        end
  endfunction

  task automatic run_frame(input int D, input int W, input int H, input bit stall,
                           input logic [63:0] base, output int nwin);
    int            n = 0;
    int            total = W*H*D;
    int            cyc = 0;
    bit            got_done = 0;
    bit            pend = 0;
    bit            held_v = 0;
    logic [WW-1:0] held = '0;
    win_t          e;
    nwin = 0;
    while ((n < total || exp_q.size() > 0 || m_valid) && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      s_valid = (n < total) && (!stall || $urandom_range(0, 2) != 0);
      s_data  = base + 64'(n);
      m_ready = !stall || ($urandom_range(0, 1) == 1);
      #1;
      if (frame_done) got_done = 1;
      if (held_v) begin
        chk("stall_hold", m_window, held);
        chk("stall_valid", WW'(m_valid), WW'(1));
        held_v = 0;
      end
      if (!stall) chk("latency", WW'(m_valid), WW'(pend));
      pend = 0;
      if (m_valid && m_ready) begin
        got_q.push_back(m_window);
        nwin++;
        if (exp_q.size() == 0) begin
          chk("extra_window", WW'(1), WW'(0));
        end else begin
          e = exp_q.pop_front();
          chk("window", m_window, e.w);
          chk("last", WW'(m_last), WW'(e.last));
        end
      end else if (m_valid) begin
        held   = m_window;
        held_v = 1;
      end
      if (s_valid && s_ready) begin
        pend = wb_q[n];
        n++;
      end
    end
    s_valid = 1'b0;
    chk("timeout", WW'(cyc < LIMIT), WW'(1));
    chk("frame_done", WW'(got_done), WW'(1));
    chk("busy_after", WW'(busy), WW'(0));
  endtask

  task automatic do_frame(input int ch, input int w, input int h, input bit k3, input bit s2,
                          input bit stall, input logic [63:0] base, output int nwin);
    start(ch, w, h, k3, s2);
    build(ch/LANES, w, h, k3, s2, base);
    run_frame(ch/LANES, w, h, stall, base, nwin);
  endtask

  int            nwin;
  int            t1v[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int            bad_cfg[5][4] = '{'{12, 4, 4, 1}, '{0, 4, 4, 1}, '{8, 2, 4, 1},
                                   '{8, 4, 2, 1}, '{16, 4097, 3, 0}};
  logic [WW-1:0] t1_first, t4_first;

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_in_channels = '0; cfg_img_width = '0;
    cfg_img_height = '0; cfg_k3 = 1'b0; cfg_stride2 = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    t1_first = '0;
    for (int i = 0; i < 9; i++) t1_first[i*DATA_W +: DATA_W] = 64'(t1v[i]);
    t4_first = WW'(64'hAB00);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", WW'(busy), WW'(0));
    chk("rst_cfg_err", WW'(cfg_err), WW'(0));
    chk("rst_s_ready", WW'(s_ready), WW'(0));
    chk("rst_m_valid", WW'(m_valid), WW'(0));
    chk("rst_m_last", WW'(m_last), WW'(0));
    chk("rst_frame_done", WW'(frame_done), WW'(0));
    chk("rst_window", m_window, '0);
    @(negedge clk);
    rst = 1'b0;

    // Bad configs: odd channel count, zero channels, too narrow, too short, line too long.
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start(bad_cfg[i][0], bad_cfg[i][1], bad_cfg[i][2], bad_cfg[i][3] != 0, 1'b0);
      chk("bad_cfg_err", WW'(cfg_err), WW'(1));
      chk("bad_cfg_busy", WW'(busy), WW'(0));
      chk("bad_cfg_s_ready", WW'(s_ready), WW'(0));
    end
    s_valid = 1'b0;

    // Exactly MAX_ROW_VECS per line is legal and clears the sticky error.
    start(8, MAX_ROW_VECS, 1, 1'b0, 1'b0);
    chk("max_rv_busy", WW'(busy), WW'(1));
    chk("max_rv_cfg_err", WW'(cfg_err), WW'(0));
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    // T1
    do_frame(8, 4, 4, 1'b1, 1'b0, 1'b0, 64'h0, nwin);
    chk("t1_count", WW'(nwin), WW'(4));
    chk("t1_first", got_q[0], t1_first);

    // T2
    do_frame(16, 4, 4, 1'b1, 1'b0, 1'b0, 64'h5000, nwin);
    chk("t2_count", WW'(nwin), WW'(8));
    chk("t2_g0_cur", WW'(got_q[0][8*DATA_W +: DATA_W]), WW'(64'h5000 + 64'd20));
    chk("t2_g1_cur", WW'(got_q[1][8*DATA_W +: DATA_W]), WW'(64'h5000 + 64'd21));
    chk("t2_g0_oldest", WW'(got_q[0][DATA_W-1:0]), WW'(64'h5000));

    // T3
    do_frame(8, 5, 5, 1'b1, 1'b1, 1'b0, 64'h9000, nwin);
    chk("t3_count", WW'(nwin), STRIDE_EN ? WW'(4) : WW'(9));
    chk("t3_first_ctr", WW'(got_q[0][4*DATA_W +: DATA_W]), WW'(64'h9000 + 64'd6));
    chk("t3_last_ctr", WW'(got_q[got_q.size()-1][4*DATA_W +: DATA_W]), WW'(64'h9000 + 64'd18));

    // T4
    do_frame(8, 3, 3, 1'b0, 1'b0, 1'b0, 64'hAB00, nwin);
    chk("t4_count", WW'(nwin), WW'(9));
    chk("t4_first", got_q[0], t4_first);

    // T5: stalls on both sides over T1 and T2
    do_frame(8, 4, 4, 1'b1, 1'b0, 1'b1, 64'h0, nwin);
    chk("t5a_count", WW'(nwin), WW'(4));
    do_frame(16, 4, 4, 1'b1, 1'b0, 1'b1, 64'h5000, nwin);
    chk("t5b_count", WW'(nwin), WW'(8));

    // T6: reset part way through T1, then a clean T1
    m_ready = 1'b1;
    start(8, 4, 4, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 64'hDEAD0000 + 64'(i);
    end
    @(negedge clk);
    s_valid = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", WW'(busy), WW'(0));
    chk("midrst_m_valid", WW'(m_valid), WW'(0));
    chk("midrst_s_ready", WW'(s_ready), WW'(0));
    do_frame(8, 4, 4, 1'b1, 1'b0, 1'b0, 64'h0, nwin);
    chk("t6_count", WW'(nwin), WW'(4));
    chk("t6_first", got_q[0], t1_first);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
